// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_pkg
//  Purpose  : Shared constants, FSM state type and small helpers for the
//             4x4 keypad scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 5;
    localparam logic [KEY_W-1:0] KEY_NONE = 5'd0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } key_state_t;

    // Code of the lowest pressed row in one column (rows are active-low),
    // or KEY_NONE. Code = row*4 + col + 1.
    function automatic logic [KEY_W-1:0] column_code(input logic [NUM_ROWS-1:0] rows_n,
                                                     input logic [1:0]          col);
        logic [KEY_W-1:0] code;
        code = KEY_NONE;
        // Walk downwards so the lowest pressed row is the last one written.
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rows_n[r]) begin
                code = KEY_W'(r * NUM_COLS) + KEY_W'(col) + KEY_W'(1);
            end
        end
        return code;
    endfunction

    // Smaller of two codes, where KEY_NONE means "nothing" rather than zero.
    function automatic logic [KEY_W-1:0] min_code(input logic [KEY_W-1:0] a,
                                                  input logic [KEY_W-1:0] b);
        logic [KEY_W-1:0] m;
        if (a == KEY_NONE) begin
            m = b;
        end else if (b == KEY_NONE) begin
            m = a;
        end else begin
            m = (a < b) ? a : b;
        end
        return m;
    endfunction

    // Active-low one-hot column drive for a column index.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(NUM_COLS'(1) << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_row_sync.sv
`default_nettype none
// ============================================================================
//  Module   : key_row_sync
//  Purpose  : Two-flop synchronizer for the asynchronous active-low keypad
//             rows. Resets to all-released (4'b1111).
//  Ports    : i_clk  - system clock
//             i_rst  - synchronous active-high reset
//             i_row  - raw keypad rows (asynchronous)
//             o_row  - synchronized rows, 2 cycles of latency
//  Revision : 1.0 - initial release
// ============================================================================
module key_row_sync
    import key_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_ROWS-1:0] i_row,
    output logic [NUM_ROWS-1:0] o_row
);

    logic [NUM_ROWS-1:0] r_meta;
    logic [NUM_ROWS-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_row = r_sync;

endmodule
`default_nettype wire

// File: rtl/key_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module   : key_matrix_scan
//  Purpose  : 4x4 membrane keypad scanner. Drives one column low at a time,
//             reads synchronized rows, reduces each scan frame to a single
//             key code (lowest index wins), debounces whole frames and emits
//             a one-cycle event carrying the 1-based key code.
//  Ports    : i_clk        - system clock
//             i_rst        - synchronous active-high reset
//             i_row[3:0]   - keypad rows, active-low, asynchronous
//             o_col[3:0]   - column drive, active-low, exactly one bit low
//             o_key_valid  - one-cycle pulse per accepted key event
//             o_key_value  - key code 0 = none, 1..16; held between events
//  Options  : KEY_REPEAT_EN - when defined, a held key re-pulses
//             o_key_valid every REPEAT_FRAMES frames.
//  Revision : 1.0 - initial release
// ============================================================================
module key_matrix_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 250
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_ROWS-1:0] i_row,
    output logic [NUM_COLS-1:0] o_col,
    output logic                o_key_valid,
    output logic [KEY_W-1:0]    o_key_value
);

    localparam int c_div_w = $clog2(SCAN_DIV);
    localparam int c_cnt_w = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int c_rep_w = $clog2(REPEAT_FRAMES + 1);

`ifdef KEY_REPEAT_EN
    localparam bit c_repeat_on = 1'b1;
`else
    localparam bit c_repeat_on = 1'b0;
`endif

    logic [NUM_ROWS-1:0] w_row_s;

    key_row_sync u_row_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_row (i_row),
        .o_row (w_row_s)
    );

    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_col_idx;
    logic [KEY_W-1:0]   r_acc;
    logic [KEY_W-1:0]   r_prev_code;
    logic [KEY_W-1:0]   r_cand;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_rep_w-1:0] r_rep_cnt;
    key_state_t         r_state;

    logic               w_step;
    logic               w_frame_end;
    logic [KEY_W-1:0]   w_code;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_cnt_done;
    logic [c_rep_w-1:0] w_rep_next;
    logic               w_rep_hit;

    assign w_step      = (r_div == c_div_w'(SCAN_DIV - 1));
    assign w_frame_end = w_step && (r_col_idx == 2'd3);

    // Running minimum over the frame; on the col3 sample this is the frame code.
    assign w_code = min_code(r_acc, column_code(w_row_s, r_col_idx));

    // Frame-to-frame stability counter, saturating at DEBOUNCE_FRAMES.
    assign w_cnt_next = (w_code != r_prev_code)                  ? c_cnt_w'(1) :
                        (r_cnt == c_cnt_w'(DEBOUNCE_FRAMES))     ? r_cnt       :
                                                                   r_cnt + c_cnt_w'(1);
    assign w_cnt_done = (w_cnt_next == c_cnt_w'(DEBOUNCE_FRAMES));

    assign w_rep_next = r_rep_cnt + c_rep_w'(1);
    assign w_rep_hit  = (w_rep_next == c_rep_w'(REPEAT_FRAMES));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div       <= '0;
            r_col_idx   <= 2'd0;
            r_acc       <= KEY_NONE;
            r_prev_code <= KEY_NONE;
            r_cand      <= KEY_NONE;
            r_cnt       <= '0;
            r_rep_cnt   <= '0;
            r_state     <= S_IDLE;
            o_col       <= 4'b1110;
            o_key_valid <= 1'b0;
            o_key_value <= KEY_NONE;
        end else begin
            o_key_valid <= 1'b0;

            if (w_step) begin
                r_div     <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                o_col     <= col_drive(r_col_idx + 2'd1);
                r_acc     <= w_frame_end ? KEY_NONE : w_code;
            end else begin
                r_div <= r_div + c_div_w'(1);
            end

            if (w_frame_end) begin
                r_prev_code <= w_code;
                r_cnt       <= w_cnt_next;

                case (r_state)
                    // In IDLE/DEBOUNCE r_prev_code always equals the candidate,
                    // so w_cnt_next alone tells whether the press is stable.
                    S_IDLE, S_DEBOUNCE: begin
                        if (w_code == KEY_NONE) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cand <= w_code;
                            if (w_cnt_done) begin
                                r_state     <= S_PRESSED;
                                r_rep_cnt   <= '0;
                                o_key_value <= w_code;
                                o_key_valid <= 1'b1;
                            end else begin
                                r_state <= S_DEBOUNCE;
                            end
                        end
                    end
                    S_PRESSED: begin
                        if (w_code == KEY_NONE) begin
                            r_rep_cnt <= '0;
                            r_state   <= w_cnt_done ? S_IDLE : S_RELEASE;
                        end else if (c_repeat_on && (w_code == r_cand)) begin
                            if (w_rep_hit) begin
                                r_rep_cnt   <= '0;
                                o_key_value <= r_cand;
                                o_key_valid <= 1'b1;
                            end else begin
                                r_rep_cnt <= w_rep_next;
                            end
                        end else begin
                            r_rep_cnt <= '0;
                        end
                    end
                    S_RELEASE: begin
                        if (w_code != KEY_NONE) begin
                            r_state <= S_PRESSED;
                        end else if (w_cnt_done) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_matrix_scan
//  Purpose  : Self-checking bench for key_matrix_scan (SCAN_DIV=4,
//             DEBOUNCE_FRAMES=3, REPEAT_FRAMES=5, 16-clock frames). Stimulus
//             pushes expected key events into a scoreboard; a monitor pops
//             and compares value and arrival cycle on every o_key_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_matrix_scan;

    localparam int FRAME = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [4:0]  key_value;

    logic [15:0] held;   // bit r*4+c set = key (r,c) held
    int          cyc;
    int          frame;
    int          checks;
    int          errors;

    typedef struct {
        logic [4:0] value;
        int         frame;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    logic [3:0] col_tab [4];

    key_matrix_scan #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3),
        .REPEAT_FRAMES   (5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_row       (row),
        .o_col       (col),
        .o_key_valid (key_valid),
        .o_key_value (key_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a held key shorts its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every pulse must match the oldest expectation in value and cycle.
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got value %0d at cycle %0d, required no pulse",
                         key_value, cyc);
            end else begin
                m_e = sb.pop_front();
                if (key_value !== m_e.value || cyc != FRAME * m_e.frame) begin
                    errors++;
                    $display("FAIL pulse: got value %0d at cycle %0d, required value %0d at cycle %0d",
                             key_value, cyc, m_e.value, FRAME * m_e.frame);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Expect a pulse at the end of the frame `offset` frames from now.
    task automatic expect_key(input logic [4:0] value, input int offset);
        exp_t e;
        e.value = value;
        e.frame = frame + offset;
        sb.push_back(e);
    endtask

    task automatic run_frames(input logic [15:0] mask, input int n);
        held = mask;
        repeat (FRAME * n) @(negedge clk);
        frame += n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        frame  = 0;
        held   = '0;
        rst    = 1'b1;
        col_tab[0] = 4'b1110;
        col_tab[1] = 4'b1101;
        col_tab[2] = 4'b1011;
        col_tab[3] = 4'b0111;

        // Reset state
        @(negedge clk);
        chk("reset_col",   int'(col), 4'b1110);
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_value", int'(key_value), 0);
        @(negedge clk);
        rst = 1'b0;

        // Column sequencing through the first (empty) frame
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("col_step_%0d", k), int'(col), int'(col_tab[(k / 4) % 4]));
        end
        frame = 1;

        // Single press r1c2 -> 7, release, press again
        expect_key(5'd7, 3);
        run_frames(16'h0040, 6);
        run_frames(16'h0000, 3);
        chk("pending_press1", sb.size(), 0);
        chk("value_held_7", int'(key_value), 7);
        expect_key(5'd7, 3);
        run_frames(16'h0040, 4);
        run_frames(16'h0000, 3);
        chk("pending_press2", sb.size(), 0);

        // Bounce on r0c0, then stable
        run_frames(16'h0001, 1);
        run_frames(16'h0000, 1);
        run_frames(16'h0001, 1);
        run_frames(16'h0000, 1);
        chk("pending_bounce", sb.size(), 0);
        expect_key(5'd1, 3);
        run_frames(16'h0001, 3);
        run_frames(16'h0000, 3);
        chk("pending_stable", sb.size(), 0);

        // Multi-key: r0c3 + r2c0 -> 4; adding r3c3 changes nothing; then r3c3 -> 16
        expect_key(5'd4, 3);
        run_frames(16'h0108, 3);
        run_frames(16'h8108, 3);
        run_frames(16'h0000, 3);
        chk("pending_multi", sb.size(), 0);
        chk("value_held_4", int'(key_value), 4);
        expect_key(5'd16, 3);
        run_frames(16'h8000, 3);
        run_frames(16'h0000, 3);
        chk("pending_r3c3", sb.size(), 0);
        chk("value_held_16", int'(key_value), 16);

        // Reset mid-debounce on r2c1, key stays held
        run_frames(16'h0200, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", int'(key_valid), 0);
        chk("midrst_value", int'(key_value), 0);
        chk("midrst_col",   int'(col), 4'b1110);
        rst   = 1'b0;
        frame = 0;
        expect_key(5'd10, 3);
        run_frames(16'h0200, 3);
        run_frames(16'h0000, 3);
        chk("pending_midrst", sb.size(), 0);

        // Long hold r0c1: auto-repeat every 5 frames when enabled
        expect_key(5'd2, 3);
`ifdef KEY_REPEAT_EN
        expect_key(5'd2, 8);
        expect_key(5'd2, 13);
        expect_key(5'd2, 18);
`endif
        run_frames(16'h0002, 20);
        run_frames(16'h0000, 3);
        chk("pending_hold", sb.size(), 0);
        chk("value_held_2", int'(key_value), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
- Scans a 4x4 membrane keypad: drives columns one at a time and reads rows through a synchronizer.
- Debounces whole scan frames and emits a one-cycle key event with a 1-based key code.
- Sits directly upstream of the 8-digit BCD key shift register. That stage consumes o_key_valid/o_key_value and computes the digit as value-1.

Parameters:
- SCAN_DIV, 50000, clocks per column step (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_FRAMES, 4, consecutive identical frames required to accept a press or a release; minimum 1.
- REPEAT_FRAMES, 250, auto-repeat period in frames; used only when KEY_REPEAT_EN is defined.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset. One clock; reset is synchronous and active-high.
- i_row  input  4  keypad rows, active-low, asynchronous (pull-ups on board).
- o_col  output 4  keypad column drive, active-low, exactly one bit low.
- o_key_valid  output 1  one-cycle pulse per accepted key event.
- o_key_value  output 5  key code: 0 = none, 1..16 = row*4+col+1. Held until the next event.

Behaviour:
- Reset values, taking effect on the next clock edge with i_rst=1:
  - o_col=4'b1110, o_key_valid=0, o_key_value=0.
  - Divider, column index and frame accumulators cleared.
  - Debounce counter cleared; FSM in S_IDLE.
- Row sync: i_row passes through a 2-FF synchronizer, giving 2 cycles of latency.
- Column sequencing:
  - The divider counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, the synchronized rows are sampled for the current column, and the column advances 0->1->2->3->0.
  - o_col is the registered one-hot-low of the column index.
- Frame code:
  - The scan order is col0..col3. Within a column, the lowest row pressed wins; across columns, the lowest key index pressed wins.
  - Key index = row*4+col; frame code = index+1, or 0 if nothing pressed.
  - Multiple keys pressed resolve to the lowest index.
  - The frame ends on the sample of col3; the code is evaluated once per frame.
- Debounce counter (cnt):
  - Resets to 1 when the frame code differs from the previous frame code.
  - Increments when the code is equal, saturating at DEBOUNCE_FRAMES.
- FSM, evaluated at frame end:
  - S_IDLE: code!=0 -> S_DEBOUNCE with cand=code, cnt=1.
  - S_DEBOUNCE:
    - code==0 -> S_IDLE.
    - code!=cand -> cand=code, cnt=1.
    - Equal and cnt reaches DEBOUNCE_FRAMES -> S_PRESSED.
    - On entry to S_PRESSED: o_key_value=cand and o_key_valid=1 for exactly one cycle, the cycle after the frame-end sample.
  - S_PRESSED: code==0 -> S_RELEASE with cnt=1. Any nonzero code, including a different key, is ignored.
  - S_RELEASE:
    - code!=0 -> S_PRESSED.
    - DEBOUNCE_FRAMES consecutive zero frames -> S_IDLE.
    - No event is emitted on release; o_key_value is retained.
- With DEBOUNCE_FRAMES=1, a press is accepted at the first frame containing it.
- Reset mid-frame or mid-debounce: immediate return to the reset state; no pending pulse is emitted.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: while in S_PRESSED with the same code, a frame counter runs. After REPEAT_FRAMES frames it re-pulses o_key_valid with the same value, then repeats every REPEAT_FRAMES frames. The counter clears on leaving S_PRESSED.
- Undefined: exactly one pulse per press, and REPEAT_FRAMES is ignored.

Decomposition:
- Package key_pkg:
  - KEY_NONE=5'd0, NUM_ROWS=4, NUM_COLS=4, KEY_W=5.
  - State enum typedef: S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE.
- Sub-module key_row_sync: the 4-bit 2-FF synchronizer, with reset to 4'b1111.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 clocks; the bench model pulls row r low when o_col[c] is low for the held key):
- Reset: assert i_rst for 2 cycles -> o_col=1110, o_key_valid=0, o_key_value=0. Release reset -> o_col steps 1101, 1011, 0111, 1110 every 4 clocks.
- Single press r1c2, held 6 frames -> exactly one pulse with o_key_value=7, one cycle after the 3rd full frame containing the key. Release for 3 frames, then press r1c2 again -> a second pulse with value 7.
- Bounce: key r0c0 present in alternate frames for 4 frames -> no pulse. Then stable for 3 frames -> one pulse with value 1.
- Multi-key: r0c3 and r2c0 held together -> one pulse with value 4. While held, adding r3c3 -> no pulse. Full release, then r3c3 -> value 16.
- Reset mid-debounce: r2c1 held 2 frames, then i_rst for 1 cycle -> no pulse, o_key_value=0, o_col=1110. The key still held afterwards -> pulse with value 10 after 3 new frames.
- KEY_REPEAT_EN with REPEAT_FRAMES=5: hold r0c1 for 20 frames -> pulses with value 2 at acceptance, then every 5 frames (4 pulses in total). Without the macro -> 1 pulse.
